// File: rtl/buffer_pkg.sv
// Shared types and default sizes for the 8-entry circular buffer and its drain logic.
package buffer_pkg;

    localparam int DATA_W    = 3;
    localparam int BUF_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } drain_state_e;

endpackage

// File: rtl/buffer_drain_summer_if.sv
// Buffer read port (rd/empty/dout) plus the valid/ready result port of buffer_drain_summer.
interface buffer_drain_summer_if #(
    parameter int DATA_W = buffer_pkg::DATA_W,
    parameter int SUM_W  = 7
) ();

    logic              rd;
    logic              empty;
    logic [DATA_W-1:0] dout;
    logic [SUM_W-1:0]  sum;
    logic              sum_valid;
    logic              sum_ready;
    logic              aborted;

    modport master (
        output rd, sum, sum_valid, aborted,
        input  empty, dout, sum_ready
    );

    modport slave (
        input  rd, sum, sum_valid, aborted,
        output empty, dout, sum_ready
    );

endinterface

// File: rtl/drain_accumulator.sv
// Captures buffer read data one cycle after each pop and sums it with a received-word count.
module drain_accumulator #(
    parameter int DATA_W = 3,
    parameter int SUM_W  = 7,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              capture_en,
    input  logic [DATA_W-1:0] din,
    output logic [SUM_W-1:0]  acc,
    output logic [CNT_W-1:0]  count
);

    // The buffer presents dout one cycle after the pop, so the pop is delayed to line up.
    logic rd_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= 1'b0;
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            rd_q  <= 1'b0;
            acc   <= '0;
            count <= '0;
        end else begin
            rd_q <= capture_en;
            if (rd_q) begin
                acc   <= acc + SUM_W'(din);
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/buffer_drain_summer.sv
// Pops BURST_LEN words from the circular buffer and offers their unsigned sum on a valid/ready port.
// Optional feature: define DRAIN_TIMEOUT_EN to abort a burst after TIMEOUT_CYC consecutive empty cycles.
module buffer_drain_summer
    import buffer_pkg::*;
#(
    parameter int DATA_W      = buffer_pkg::DATA_W,
    parameter int BURST_LEN   = buffer_pkg::BUF_DEPTH,
    parameter int SUM_W       = 7,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    buffer_drain_summer_if.master bus
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_burst_len_check
        $error("buffer_drain_summer: BURST_LEN must lie in 1..255");
    end
    if (SUM_W < DATA_W + $clog2(BURST_LEN + 1)) begin : g_sum_w_check
        $error("buffer_drain_summer: SUM_W too narrow for the largest possible sum");
    end
    if (TIMEOUT_CYC < 1) begin : g_timeout_check
        $error("buffer_drain_summer: TIMEOUT_CYC must be at least 1");
    end

    drain_state_e     state;
    drain_state_e     state_next;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] recv_cnt;
    logic [SUM_W-1:0] acc;
    logic             rd;
    logic             sum_valid;
    logic             start_accept;
    logic             last_pop;
    logic             drain_done;
    logic             timeout_hit;

    // rd is purely combinational from state and empty, so no pop can ever hit an empty buffer.
    assign rd           = (state == READ) && !bus.empty;
    assign start_accept = (state == IDLE) && start;
    assign last_pop     = rd && (issue_cnt == CNT_W'(BURST_LEN - 1));
    // At most one capture is outstanding on entry to DRAIN and it lands on the next edge.
    assign drain_done   = (issue_cnt - recv_cnt) <= CNT_W'(1);
    assign sum_valid    = (state == DONE);
    assign busy         = (state != IDLE);

    assign bus.rd        = rd;
    assign bus.sum_valid = sum_valid;
    assign bus.sum       = sum_valid ? acc : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
        end else begin
            state <= state_next;
            if (start_accept) begin
                issue_cnt <= '0;
            end else if (rd) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (last_pop || timeout_hit) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = DONE;
            DONE:    if (bus.sum_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef DRAIN_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               aborted_q;

    // In READ a cycle without a pop is exactly a cycle with the buffer empty.
    assign timeout_hit = (state == READ) && bus.empty
                         && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            aborted_q <= 1'b0;
        end else if (start_accept) begin
            stall_cnt <= '0;
            aborted_q <= 1'b0;
        end else if (state == READ) begin
            if (rd) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if (timeout_hit) begin
                aborted_q <= 1'b1;
            end
        end
    end

    assign bus.aborted = sum_valid && aborted_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.aborted = 1'b0;
`endif

    drain_accumulator #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .CNT_W  (CNT_W)
    ) u_accumulator (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (start_accept),
        .capture_en (rd),
        .din        (bus.dout),
        .acc        (acc),
        .count      (recv_cnt)
    );

endmodule

// File: tb/tb_buffer_drain_summer.sv
// Directed bench for buffer_drain_summer with a behavioural 8-entry circular buffer on the read port.
module tb_buffer_drain_summer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       busy;
    logic       wr_en;
    logic [2:0] wr_data;

    int checks   = 0;
    int failures = 0;

    buffer_drain_summer_if #(.DATA_W(3), .SUM_W(7)) bif ();

    buffer_drain_summer #(
        .DATA_W      (3),
        .BURST_LEN   (8),
        .SUM_W       (7),
        .TIMEOUT_CYC (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .bus     (bif)
    );

    always #5 clock = ~clock;

    // Behavioural circular buffer: push from the bench, pop on rd, dout valid the cycle after rd.
    logic [2:0] mem [8];
    int         wp   = 0;
    int         rp   = 0;
    int         fill = 0;

    assign bif.empty = (fill == 0);

    always @(posedge clock) begin
        if (bif.rd) begin
            bif.dout <= mem[rp];
            rp       <= (rp + 1) % 8;
        end
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= (wp + 1) % 8;
        end
        fill <= fill + (wr_en ? 1 : 0) - (bif.rd ? 1 : 0);
    end

    int rd_pulses  = 0;
    int empty_viol = 0;

    always @(negedge clock) begin
        if (bif.rd) rd_pulses <= rd_pulses + 1;
        if (bif.rd && bif.empty) empty_viol <= empty_viol + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

    task automatic push(input logic [2:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    // First word in the most significant slot.
    task automatic push8(input logic [23:0] ws);
        for (int i = 0; i < 8; i++) push(ws[23 - 3*i -: 3]);
    endtask

    // Pulses start and counts edges until sum_valid is seen (64 if it never appears).
    task automatic start_and_count(output int cyc);
        start = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            if (bif.sum_valid) break;
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clock);
            if (bif.sum_valid) ok = 1'b1;
        end
    endtask

    task automatic take_result();
        bif.sum_ready = 1'b1;
        @(negedge clock);
        bif.sum_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bif.rd !== 1'b0) begin failures++; $display("FAIL reset_rd: got %b want 0", bif.rd); end
        checks++; if (bif.sum_valid !== 1'b0) begin failures++; $display("FAIL reset_sum_valid: got %b want 0", bif.sum_valid); end
        checks++; if (bif.sum !== 7'd0) begin failures++; $display("FAIL reset_sum: got %0d want 0", bif.sum); end
        checks++; if (bif.aborted !== 1'b0) begin failures++; $display("FAIL reset_aborted: got %b want 0", bif.aborted); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_full_burst();
        int cyc;
        int base;
        push8({3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd7});
        base = rd_pulses;
        start_and_count(cyc);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL full_latency: got %0d cycles want 10", cyc); end
        checks++; if (bif.sum !== 7'd55) begin failures++; $display("FAIL full_sum: got %0d want 55", bif.sum); end
        checks++; if (bif.aborted !== 1'b0) begin failures++; $display("FAIL full_aborted: got %b want 0", bif.aborted); end
        checks++; if (rd_pulses - base !== 8) begin failures++; $display("FAIL full_rd_count: got %0d want 8", rd_pulses - base); end
        checks++; if (empty_viol !== 0) begin failures++; $display("FAIL full_rd_empty: got %0d want 0", empty_viol); end
        take_result();
        checks++; if (bif.sum_valid !== 1'b0) begin failures++; $display("FAIL full_valid_drop: got %b want 0", bif.sum_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_max_value();
        int cyc;
        push8({8{3'd7}});
        start_and_count(cyc);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL max_latency: got %0d cycles want 10", cyc); end
        checks++; if (bif.sum !== 7'd56) begin failures++; $display("FAIL max_sum: got %0d want 56", bif.sum); end
        take_result();
    endtask

    task automatic test_stall();
        int base;
        bit ok;
        repeat (3) push(3'd1);
        base  = rd_pulses;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy: got %b want 1", busy); end
        checks++; if (bif.rd !== 1'b0) begin failures++; $display("FAIL stall_rd: got %b want 0", bif.rd); end
        repeat (5) push(3'd2);
        wait_valid(32, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b want 1", ok); end
        checks++; if (bif.sum !== 7'd13) begin failures++; $display("FAIL stall_sum: got %0d want 13", bif.sum); end
        checks++; if (rd_pulses - base !== 8) begin failures++; $display("FAIL stall_rd_count: got %0d want 8", rd_pulses - base); end
        checks++; if (empty_viol !== 0) begin failures++; $display("FAIL stall_rd_empty: got %0d want 0", empty_viol); end
        take_result();
    endtask

    task automatic test_backpressure();
        int cyc;
        int base;
        push8({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0});
        start_and_count(cyc);
        checks++; if (bif.sum_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_rise: got %b want 1", bif.sum_valid); end
        base = rd_pulses;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clock);
            checks++; if (bif.sum_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, bif.sum_valid); end
            checks++; if (bif.sum !== 7'd28) begin failures++; $display("FAIL bp_sum_hold[%0d]: got %0d want 28", i, bif.sum); end
        end
        start = 1'b0;
        take_result();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle: got busy %b want 0", busy); end
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_start_ignored: got busy %b want 0", busy); end
        checks++; if (rd_pulses - base !== 0) begin failures++; $display("FAIL bp_no_pop: got %0d pops want 0", rd_pulses - base); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        push8({8{3'd1}});
        bif.sum_ready = 1'b1;
        start_and_count(cyc);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL b2b_latency: got %0d cycles want 10", cyc); end
        checks++; if (bif.sum !== 7'd8) begin failures++; $display("FAIL b2b_sum1: got %0d want 8", bif.sum); end
        @(negedge clock);
        checks++; if (bif.sum_valid !== 1'b0) begin failures++; $display("FAIL b2b_one_cycle_done: got %b want 0", bif.sum_valid); end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_start_taken: got busy %b want 1", busy); end
        repeat (8) push(3'd2);
        wait_valid(32, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_valid2: got %b want 1", ok); end
        checks++; if (bif.sum !== 7'd16) begin failures++; $display("FAIL b2b_sum2: got %0d want 16", bif.sum); end
        bif.sum_ready = 1'b0;
        @(negedge clock);
        take_result();
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        push8({3'd7, 3'd7, 3'd7, 3'd7, 3'd1, 3'd1, 3'd1, 3'd1});
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (bif.rd !== 1'b0) begin failures++; $display("FAIL rst_mid_rd: got %b want 0", bif.rd); end
        checks++; if ({bif.sum_valid, bif.sum} !== 8'd0) begin failures++; $display("FAIL rst_mid_result: got %h want 0", {bif.sum_valid, bif.sum}); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) push(3'd2);
        wait_valid(32, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rst_mid_valid: got %b want 1", ok); end
        checks++; if (bif.sum !== 7'd12) begin failures++; $display("FAIL rst_mid_sum: got %0d want 12", bif.sum); end
        take_result();
    endtask

`ifdef DRAIN_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        push(3'd5);
        push(3'd5);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_valid(64, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL timeout_valid: got %b want 1", ok); end
        checks++; if (bif.sum !== 7'd10) begin failures++; $display("FAIL timeout_sum: got %0d want 10", bif.sum); end
        checks++; if (bif.aborted !== 1'b1) begin failures++; $display("FAIL timeout_aborted: got %b want 1", bif.aborted); end
        take_result();
    endtask
`endif

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        wr_en         = 1'b0;
        wr_data       = 3'd0;
        bif.sum_ready = 1'b0;
        test_reset();
        test_full_burst();
        test_max_value();
        test_stall();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef DRAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffer_drain_summer.md
# buffer_drain_summer

Downstream consumer for the 8-entry circular buffer. On a start pulse it pops exactly BURST_LEN words through the buffer's rd/empty/dout interface, never reading while the buffer is empty. It accumulates the words into an unsigned sum and presents that sum on a valid/ready result port, holding it until the result is taken.

## Interface
- DATA_W, 3: width of one buffer word
- BURST_LEN, 8: words popped per burst; legal range 1..255
- SUM_W, 7: width of the sum; must be ≥ DATA_W + $clog2(BURST_LEN+1)
- TIMEOUT_CYC, 16: consecutive empty cycles before abort; used only when the timeout feature is compiled in
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a burst; ignored unless in IDLE
- empty  in  1  buffer empty flag
- rd  out  1  pop request to the buffer
- dout  in  DATA_W  buffer read data, valid on the cycle after an accepted rd
- sum  out  SUM_W  accumulated result
- sum_valid  out  1  sum is stable and may be taken
- sum_ready  in  1  consumer accepts sum
- busy  out  1  high in every state except IDLE
- aborted  out  1  result was ended by timeout; valid while sum_valid is high

## Operation
- Reset value of every output is 0. The FSM resets to IDLE and all counters clear.
- IDLE:
  - If start is high: clear the accumulator, word count and stall count, then go to READ.
- READ:
  - rd = !empty. This is combinational from empty and state, so no pop is ever issued while empty.
  - Each accepted pop increments issue_cnt.
  - When issue_cnt reaches BURST_LEN on an accepted pop, go to DRAIN.
- DRAIN:
  - rd = 0. Wait for the final dout capture, then go to DONE.
- Capture:
  - Register rd_q = rd.
  - When rd_q is high: acc <= acc + zero-extended dout, and recv_cnt increments.
  - Capture is active in READ and in DRAIN.
- DONE:
  - sum = acc and sum_valid = 1, held stable until sum_ready.
  - On sum_valid && sum_ready, go to IDLE on the next edge, with sum_valid = 0.
- Arithmetic: unsigned, no wrap. The SUM_W rule guarantees the maximum (2^DATA_W − 1)·BURST_LEN fits.
- start while busy: ignored, no effect on the counters.
- empty toggling mid-burst: READ stalls with rd = 0 and resumes when empty falls. The sum is unaffected.
- Reset asserted mid-burst: the block returns to IDLE immediately (asynchronously), and the partial sum is discarded. Words already popped are lost. That is acceptable and is the system's responsibility.

## Timing
- rd is asserted in the same cycle that empty is low in READ, so the latency from empty falling to rd is 0 cycles.
- dout is sampled on the edge one cycle after the rd edge.
- Minimum burst, with the buffer never empty:
  - 1 cycle IDLE→READ
  - BURST_LEN cycles of rd
  - 1 cycle DRAIN
  - sum_valid rises on the following edge
  - Total: start to sum_valid = BURST_LEN + 2 cycles.
- sum_valid && sum_ready in the same cycle that sum_valid first rises is legal. That gives a one-cycle DONE.
- Back-to-back bursts: a start arriving in the cycle after DONE is accepted, because the FSM is in IDLE by then.

## Configuration
- DRAIN_TIMEOUT_EN defined:
  - In READ, stall_cnt counts consecutive cycles with empty high and resets on any accepted pop.
  - When stall_cnt reaches TIMEOUT_CYC, go to DRAIN. The partial sum is delivered with aborted = 1.
- DRAIN_TIMEOUT_EN undefined:
  - READ waits indefinitely.
  - aborted is tied to 0, and no stall counter is built.

## Structure
- Shared package buffer_pkg:
  - drain_state_e enum {IDLE, READ, DRAIN, DONE}
  - Default constants DATA_W and BUF_DEPTH (8), shared with the circular buffer.
- One sub-module, drain_accumulator: holds acc, recv_cnt and the rd_q capture register. Its ports are clear, capture_en, din, acc and count.
- FSM, issue counter and timeout logic live in the top module.
- An elaboration-time check rejects a SUM_W that is too narrow.

## Test plan
- Full burst: prefill the buffer with 7,7,7,7,7,7,6,7 then pulse start.
  - sum = 55, aborted = 0.
  - Exactly 8 rd pulses; sum_valid appears BURST_LEN+2 = 10 cycles after start.
- Stall mid-burst:
  - Stimulus: prefill 3 words of 1, pulse start. Write 5 more words of 2 after a 6-cycle gap.
  - Response: rd is never high while empty; sum = 13.
- Result backpressure:
  - Stimulus: hold sum_ready = 0 for 5 cycles after sum_valid rises; pulse start during that time.
  - Response: sum and sum_valid are stable; start is ignored; IDLE is reached only after the handshake.
- Maximum value:
  - Stimulus: 8 words of 7 (3'b111).
  - Response: sum = 56, with no overflow in 7 bits.
- Reset mid-burst:
  - Stimulus: drop reset_n after 4 pops.
  - Response: all outputs go to 0 immediately; a new start yields a sum of only the newly popped words.
- With DRAIN_TIMEOUT_EN, TIMEOUT_CYC = 16:
  - Stimulus: 2 words of 5, then the buffer stays empty.
  - Response: after 16 stalled cycles, sum = 10 and aborted = 1.
